// File: rtl/reg_file_sb.sv
// Register file with two combinational read ports, one write-back port and a per-register
// scoreboard (busy bits) set by issue-side allocates and cleared by write-back.
module reg_file_sb #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned NUM_REGS   = 2 ** ADDR_WIDTH,
  parameter bit          ZERO_REG   = 1'b1,
  parameter bit          BYPASS     = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] raddr1,
  input  logic [ADDR_WIDTH-1:0] raddr2,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic [DATA_WIDTH-1:0] rdata2,
  output logic                  rbusy1,
  output logic                  rbusy2,
  input  logic                  wen,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  alloc_en,
  input  logic [ADDR_WIDTH-1:0] alloc_addr,
  output logic [ADDR_WIDTH:0]   pending_cnt,
  output logic                  alloc_err
);

  localparam int unsigned CW = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] mem_q [NUM_REGS];
  logic [NUM_REGS-1:0]   busy_q, busy_d;
  logic [CW-1:0]         pending_q, pending_d;
  logic                  alloc_err_q, alloc_err_d;
  logic                  wr_eff, al_eff, same_addr, alloc_set, wb_clr;

  // Implemented and not the hardwired zero register.
  function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
    return (32'(a) < NUM_REGS) && !(ZERO_REG && (a == '0));
  endfunction

  assign wr_eff    = wen && addr_ok(waddr);
  assign al_eff    = alloc_en && addr_ok(alloc_addr);
  assign same_addr = wr_eff && al_eff && (waddr == alloc_addr);

  always_comb begin
    busy_d = busy_q;
    if (wr_eff) busy_d[waddr] = 1'b0;
    // Allocate wins over a same-address write-back: the new producer replaces the old one.
    if (al_eff) busy_d[alloc_addr] = 1'b1;
    alloc_set   = al_eff && !busy_q[alloc_addr];
    wb_clr      = wr_eff && busy_q[waddr] && !same_addr;
    pending_d   = pending_q + CW'(alloc_set) - CW'(wb_clr);
    alloc_err_d = al_eff && busy_q[alloc_addr] && !same_addr;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) mem_q[i] <= '0;
      busy_q      <= '0;
      pending_q   <= '0;
      alloc_err_q <= 1'b0;
    end else begin
      if (wr_eff) mem_q[waddr] <= wdata;
      busy_q      <= busy_d;
      pending_q   <= pending_d;
      alloc_err_q <= alloc_err_d;
    end
  end

  function automatic logic [DATA_WIDTH-1:0] rd_data(input logic [ADDR_WIDTH-1:0] a);
    if (!addr_ok(a)) return '0;
    if (BYPASS && wr_eff && (waddr == a)) return wdata;
    return mem_q[a];
  endfunction

  // A bypassed write-back hides the busy bit unless an allocate re-claims the same register.
  function automatic logic rd_busy(input logic [ADDR_WIDTH-1:0] a);
    if (!addr_ok(a)) return 1'b0;
    return busy_q[a] && !(BYPASS && wr_eff && (waddr == a) && !same_addr);
  endfunction

  assign rdata1      = rd_data(raddr1);
  assign rdata2      = rd_data(raddr2);
  assign rbusy1      = rd_busy(raddr1);
  assign rbusy2      = rd_busy(raddr2);
  assign pending_cnt = pending_q;
  assign alloc_err   = alloc_err_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Scoreboard bench for reg_file_sb: one instance with bypass, one without, sharing stimulus.
module tb_reg_file_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  raddr1, raddr2, waddr, alloc_addr;
  logic [31:0] wdata;
  logic        wen, alloc_en;

  logic [31:0] rdata1_b, rdata2_b, rdata1_n, rdata2_n;
  logic        rbusy1_b, rbusy2_b, rbusy1_n, rbusy2_n;
  logic [5:0]  pend_b, pend_n;
  logic        aerr_b, aerr_n;

  int total = 0;
  int bad   = 0;

  localparam int RD1 = 0, RD2 = 1, BS1 = 2, BS2 = 3, PEND = 4, AERR = 5;
  localparam int RD1N = 6, BS1N = 7, PENDN = 8;

  typedef struct {
    string       tag;
    int          sig;
    logic [31:0] exp;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] vals [32];

  always #5 clk = ~clk;

  reg_file_sb #(.BYPASS(1'b1)) u_bp (
    .clk(clk), .rst(rst), .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1_b),
    .rdata2(rdata2_b), .rbusy1(rbusy1_b), .rbusy2(rbusy2_b), .wen(wen), .waddr(waddr),
    .wdata(wdata), .alloc_en(alloc_en), .alloc_addr(alloc_addr), .pending_cnt(pend_b),
    .alloc_err(aerr_b)
  );

  reg_file_sb #(.BYPASS(1'b0)) u_nb (
    .clk(clk), .rst(rst), .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1_n),
    .rdata2(rdata2_n), .rbusy1(rbusy1_n), .rbusy2(rbusy2_n), .wen(wen), .waddr(waddr),
    .wdata(wdata), .alloc_en(alloc_en), .alloc_addr(alloc_addr), .pending_cnt(pend_n),
    .alloc_err(aerr_n)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input int sig, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.sig = sig;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t        e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.sig)
        RD1:     obs = rdata1_b;
        RD2:     obs = rdata2_b;
        BS1:     obs = 32'(rbusy1_b);
        BS2:     obs = 32'(rbusy2_b);
        PEND:    obs = 32'(pend_b);
        AERR:    obs = 32'(aerr_b);
        RD1N:    obs = rdata1_n;
        BS1N:    obs = 32'(rbusy1_n);
        PENDN:   obs = 32'(pend_n);
        default: obs = 'x;
      endcase
      check(e.tag, obs, e.exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    #1;
    drain();
  endtask

  task automatic idle();
    wen      = 1'b0;
    alloc_en = 1'b0;
  endtask

  initial begin
    rst = 1'b0; wen = 1'b0; alloc_en = 1'b0; waddr = '0; wdata = '0;
    alloc_addr = '0; raddr1 = '0; raddr2 = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Reset in the middle of a run.
    wen = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
    alloc_en = 1'b1; alloc_addr = 5'd7; raddr1 = 5'd5; raddr2 = 5'd7;
    step(); idle();
    push("pre_rst_rd", RD1, 32'hDEADBEEF); push("pre_rst_bsy", BS2, 1); push("pre_rst_cnt", PEND, 1);
    look();
    rst = 1'b0;
    #1;
    push("rst_rd", RD1, 0); push("rst_bsy", BS2, 0); push("rst_cnt", PEND, 0);
    push("rst_err", AERR, 0); push("rst_rd_nb", RD1N, 0); push("rst_cnt_nb", PENDN, 0);
    drain();
    #1 rst = 1'b1;

    // Register 0 ignores writes and allocates.
    step();
    wen = 1'b1; waddr = 5'd0; wdata = 32'h1234; alloc_en = 1'b1; alloc_addr = 5'd0;
    raddr1 = 5'd0; raddr2 = 5'd0;
    push("r0_byp_rd", RD1, 0); push("r0_byp_bsy", BS1, 0);
    look();
    step(); idle();
    push("r0_rd1", RD1, 0); push("r0_rd2", RD2, 0); push("r0_bsy", BS1, 0);
    push("r0_cnt", PEND, 0); push("r0_err", AERR, 0);
    look();

    // Bypass vs. no bypass on a pending register.
    wen = 1'b1; waddr = 5'd3; wdata = 32'h11111111;
    step();
    wen = 1'b0; alloc_en = 1'b1; alloc_addr = 5'd3;
    step();
    alloc_en = 1'b0; wen = 1'b1; waddr = 5'd3; wdata = 32'hA5A5A5A5; raddr1 = 5'd3;
    push("byp_rd", RD1, 32'hA5A5A5A5); push("byp_bsy", BS1, 0); push("byp_cnt", PEND, 1);
    push("nb_rd_old", RD1N, 32'h11111111); push("nb_bsy", BS1N, 1); push("nb_cnt", PENDN, 1);
    look();
    step(); idle();
    push("byp_cnt_after", PEND, 0); push("byp_rd_after", RD1, 32'hA5A5A5A5);
    push("byp_bsy_after", BS1, 0); push("nb_rd_after", RD1N, 32'hA5A5A5A5);
    push("nb_bsy_after", BS1N, 0); push("nb_cnt_after", PENDN, 0);
    look();

    // WAW allocate on r9.
    alloc_en = 1'b1; alloc_addr = 5'd9; raddr1 = 5'd9;
    push("waw_own_cycle_bsy", BS1, 0);
    look();
    step();
    push("waw_bsy1", BS1, 1); push("waw_cnt1", PEND, 1); push("waw_err1", AERR, 0);
    look();
    step(); idle();
    push("waw_err_pulse", AERR, 1); push("waw_cnt2", PEND, 1); push("waw_bsy2", BS1, 1);
    look();
    step();
    push("waw_err_drop", AERR, 0);
    look();
    wen = 1'b1; waddr = 5'd9; wdata = 32'h99;
    push("waw_wb_byp_bsy", BS1, 0); push("waw_wb_byp_rd", RD1, 32'h99);
    push("waw_wb_nb_bsy", BS1N, 1);
    look();
    step(); idle();
    push("waw_clr_cnt", PEND, 0); push("waw_clr_bsy", BS1, 0); push("waw_clr_rd", RD1, 32'h99);
    push("waw_clr_nb_bsy", BS1N, 0); push("waw_clr_nb_cnt", PENDN, 0);
    look();

    // Same-cycle allocate and write-back to busy r12.
    alloc_en = 1'b1; alloc_addr = 5'd12; raddr1 = 5'd12;
    step();
    wen = 1'b1; waddr = 5'd12; wdata = 32'h00C0FFEE;
    push("same_byp_rd", RD1, 32'h00C0FFEE); push("same_byp_bsy", BS1, 1);
    push("same_cnt0", PEND, 1);
    look();
    step(); idle();
    push("same_rd", RD1, 32'h00C0FFEE); push("same_bsy", BS1, 1); push("same_cnt", PEND, 1);
    push("same_err", AERR, 0); push("same_nb_rd", RD1N, 32'h00C0FFEE);
    push("same_nb_bsy", BS1N, 1);
    look();
    wen = 1'b1; waddr = 5'd12; wdata = 32'h0;
    step(); idle();
    push("same_cleanup_cnt", PEND, 0);
    look();

    // Fill every register, then drain.
    for (int i = 1; i < 32; i++) begin
      alloc_en = 1'b1; alloc_addr = 5'(i);
      step();
    end
    idle();
    push("fill_cnt", PEND, 31); push("fill_cnt_nb", PENDN, 31);
    look();
    for (int i = 1; i < 32; i++) begin
      vals[i] = ($urandom() & 32'hFFFF_FF00) | 32'(i);
      wen = 1'b1; waddr = 5'(i); wdata = vals[i];
      step();
    end
    idle();
    push("drain_cnt", PEND, 0); push("drain_cnt_nb", PENDN, 0);
    look();
    for (int i = 1; i < 32; i++) begin
      raddr1 = 5'(i); raddr2 = 5'(i);
      push($sformatf("fill_rd1_r%0d", i), RD1, vals[i]);
      push($sformatf("fill_rd2_r%0d", i), RD2, vals[i]);
      push($sformatf("fill_bsy_r%0d", i), BS1, 0);
      push($sformatf("fill_nb_rd_r%0d", i), RD1N, vals[i]);
      look();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised MIPS register file with a per-register scoreboard, for the multi-cycle core. One write-back port and two asynchronous read ports. Optional write-to-read bypass. An issue-side allocate port marks destination registers pending until their write-back lands, so decode can detect RAW hazards from the `rbusy` flags without external bookkeeping.

## Interface
**Parameters**
- `DATA_WIDTH`, 32: register width in bits.
- `ADDR_WIDTH`, 5: register address width.
- `NUM_REGS`, 2**`ADDR_WIDTH`: implemented registers. Must be ≤ 2**`ADDR_WIDTH`. Addresses ≥ `NUM_REGS` read 0, read not busy, and ignore writes and allocates.
- `ZERO_REG`, 1: when 1, register 0 is hardwired to 0 and never busy.
- `BYPASS`, 1: when 1, same-cycle write-back data is forwarded to the read ports.

**Ports**
- `clk` in 1: clock. All state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-low. Clears all state.
- `raddr1` in `ADDR_WIDTH`: read address, port 1.
- `raddr2` in `ADDR_WIDTH`: read address, port 2.
- `rdata1` out `DATA_WIDTH`: read data, port 1. Combinational.
- `rdata2` out `DATA_WIDTH`: read data, port 2. Combinational.
- `rbusy1` out 1: `raddr1` has an outstanding producer. Combinational.
- `rbusy2` out 1: `raddr2` has an outstanding producer. Combinational.
- `wen` in 1: write-back enable.
- `waddr` in `ADDR_WIDTH`: write-back address.
- `wdata` in `DATA_WIDTH`: write-back data.
- `alloc_en` in 1: an instruction with a destination register issues this cycle.
- `alloc_addr` in `ADDR_WIDTH`: destination register being allocated.
- `pending_cnt` out `ADDR_WIDTH`+1: number of busy registers. Registered.
- `alloc_err` out 1: one-cycle pulse, registered. Asserted the cycle after an allocate targets a register that is already busy.

## Operation
- **Storage:** `NUM_REGS` × `DATA_WIDTH` data array, plus a `NUM_REGS`-bit busy vector.
- **Write:** on a rising edge with `wen`=1 and a valid `waddr`, `reg[waddr]` ← `wdata` and `busy[waddr]` ← 0.
  - If `ZERO_REG`=1 and `waddr`=0, the write is dropped.
- **Allocate:** on a rising edge with `alloc_en`=1 and a valid `alloc_addr`, `busy[alloc_addr]` ← 1.
  - If `ZERO_REG`=1 and `alloc_addr`=0, the allocate is ignored.
  - Allocating an already-busy register (WAW) keeps the bit at 1. `pending_cnt` is unchanged and `alloc_err` pulses. The first write-back to that register clears the bit.
- **Allocate and write-back to the same address in the same cycle:** allocate wins. Data is written, `busy` ends at 1, `pending_cnt` is unchanged and `alloc_err` stays 0. This is the new producer replacing the old one.
- **Allocate and write-back to different addresses in the same cycle:** both take effect.
- **`pending_cnt`:** next value = current + (effective new set) − (effective clear). An effective clear is a write-back to a busy register with no same-address allocate. Range 0..`NUM_REGS`; it cannot overflow.
- **Write-back to a non-busy register:** legal. Data is written and `pending_cnt` is unchanged.
- **Read, `BYPASS`=1:** if `wen`=1 and `waddr`==`raddrN` (and the write is not dropped), then `rdataN`=`wdata`. In addition, `rbusyN` = `busy[raddrN]` AND NOT that bypass condition, unless a same-address allocate is also present (see Timing).
- **Read, `BYPASS`=0:** `rdataN` = `reg[raddrN]` and `rbusyN` = `busy[raddrN]`. A write is visible only after the edge.
- **Reading register 0** with `ZERO_REG`=1 always gives `rdata`=0 and `rbusy`=0.
- **Both read ports** may address the same register in the same cycle with no restriction.

## Timing
- **Reset** (`rst`=0, asynchronous, held any length): all registers 0, busy vector 0, `pending_cnt`=0, `alloc_err`=0. Consequently `rdataN`=0 and `rbusyN`=0.
- **Reset release:** the first edge with `rst`=1 may write or allocate.
- **Reset mid-operation:** all in-flight busy state is discarded. The issuing stage must also be flushed.
- **Write latency:** 1 edge.
- **Read latency:** 0 cycles (combinational). A bypassed read sees `wdata` in the same cycle.
- **Allocate latency:** the busy bit is visible on `rbusy` from the cycle after the allocate edge. An allocate does not affect `rbusy` in its own cycle.
- **`alloc_err`:** high exactly one cycle following the offending edge. Back-to-back violations give back-to-back pulses.
- **No handshake:** the block never stalls. Hazard policy belongs to decode.

## Test plan
- **Reset:** assert `rst`=0 mid-run after writing `reg[5]`=0xDEADBEEF and allocating r7. Required: `rdata1`(r5)=0 immediately (asynchronous), r7 not busy, `pending_cnt`=0, `alloc_err`=0.
- **Zero register:** write 0x1234 to r0 and allocate r0. Required: r0 reads 0, `rbusy`=0, `pending_cnt`=0.
- **Bypass:** `BYPASS`=1; allocate r3, then next cycle `wen`=1, `waddr`=3, `wdata`=0xA5A5A5A5 with `raddr1`=3. Required: same cycle `rdata1`=0xA5A5A5A5 and `rbusy1`=0; `pending_cnt` goes 1→0. With `BYPASS`=0: `rdata1`=old value and `rbusy1`=1 that cycle; correct data the next cycle.
- **WAW:** allocate r9 twice on consecutive cycles. Required: `alloc_err` pulses one cycle after the second allocate and `pending_cnt`=1. A single write-back to r9 clears busy and `pending_cnt`=0.
- **Same-cycle allocate + write-back, r12 busy:** required: data written, r12 still busy, `pending_cnt` unchanged, no `alloc_err`.
- **Fill:** allocate r1..r31 on successive cycles. Required: `pending_cnt`=31. Write back all 31, each with a distinct random value. Required: `pending_cnt`=0 and all 31 values read back correctly on both ports.
